// File: rtl/nn_pkg.sv
// Shared definitions for the matrix-vector engine: default widths and FSM state encoding.
package nn_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 8;
   localparam int unsigned ACC_WIDTH      = 2 * DATA_WIDTH_DEF;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_EMIT = 2'd2,
      S_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/signed_mac.sv
// Signed multiply-accumulate step (combinational).
// Ports: i_a/i_b signed operands, i_acc running sum, i_clear forces zero,
//        i_en adds the full-width product, o_acc_c next accumulator value.
module signed_mac
   import nn_pkg::*;
#(
   parameter int unsigned DW = DATA_WIDTH_DEF,
   parameter int unsigned AW = ACC_WIDTH
) (
   input  logic signed [DW-1:0] i_a,
   input  logic signed [DW-1:0] i_b,
   input  logic signed [AW-1:0] i_acc,
   input  logic                 i_clear,
   input  logic                 i_en,
   output logic signed [AW-1:0] o_acc_c
);

   logic signed [AW-1:0] w_prod;

   // Sign-extend both operands before multiplying; the sum wraps modulo 2^AW.
   assign w_prod = AW'(i_a) * AW'(i_b);

   always_comb begin
      o_acc_c = i_acc;
      if (i_clear) begin
         o_acc_c = '0;
      end else if (i_en) begin
         o_acc_c = i_acc + w_prod;
      end
   end

endmodule

// File: rtl/matrix_vector_engine.sv
// Matrix-vector engine: computes y = W*x one row at a time and hands each row
// result downstream with a valid/ready handshake.
// Ports: clk, rst_n (async active-low); start; weight write (w_in, w_wen, w_row,
//        w_col); vector write (x_in, x_wen, x_addr); out_ready; outputs
//        matrix_result, matrix_valid, result_idx, busy, done.
module matrix_vector_engine
   import nn_pkg::*;
#(
   parameter  int unsigned M          = 3,
   parameter  int unsigned N          = 3,
   parameter  int unsigned DATA_WIDTH = 8,
   localparam int unsigned RW         = (M > 1) ? $clog2(M) : 1,
   localparam int unsigned CW         = (N > 1) ? $clog2(N) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic signed [DATA_WIDTH-1:0]   w_in,
   input  logic                           w_wen,
   input  logic [RW-1:0]                  w_row,
   input  logic [CW-1:0]                  w_col,
   input  logic signed [DATA_WIDTH-1:0]   x_in,
   input  logic                           x_wen,
   input  logic [CW-1:0]                  x_addr,
   input  logic                           out_ready,
   output logic signed [2*DATA_WIDTH-1:0] matrix_result,
   output logic                           matrix_valid,
   output logic [RW-1:0]                  result_idx,
   output logic                           busy,
   output logic                           done
);

   localparam int unsigned AW = 2 * DATA_WIDTH;

   logic signed [DATA_WIDTH-1:0] r_w [M][N];
   logic signed [DATA_WIDTH-1:0] r_x [N];

   state_e                r_state;
   logic [RW-1:0]         r_row;
   logic [CW-1:0]         r_col;
   logic signed [AW-1:0]  r_acc;
   logic signed [AW-1:0]  w_mac_acc;
   logic                  w_mac_en;
   logic                  w_mac_clear;
   logic                  w_last_col;
   logic                  w_last_row;

   assign w_mac_en    = (r_state == S_MAC);
   assign w_mac_clear = (r_state != S_MAC);
   assign w_last_col  = (r_col == CW'(N - 1));
   assign w_last_row  = (r_row == RW'(M - 1));

   // Operand storage: writable only while idle, deliberately untouched by reset.
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE) begin
         if (w_wen) r_w[w_row][w_col] <= w_in;
         if (x_wen) r_x[x_addr]       <= x_in;
      end
   end

   signed_mac #(
      .DW (DATA_WIDTH),
      .AW (AW)
   ) u_mac (
      .i_a     (r_w[r_row][r_col]),
      .i_b     (r_x[r_col]),
      .i_acc   (r_acc),
      .i_clear (w_mac_clear),
      .i_en    (w_mac_en),
      .o_acc_c (w_mac_acc)
   );

   // Accumulator stays cleared outside MAC, so each row starts from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_acc <= '0;
      else        r_acc <= w_mac_acc;
   end

   // Control FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_row         <= '0;
         r_col         <= '0;
         matrix_result <= '0;
         matrix_valid  <= 1'b0;
         result_idx    <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_MAC;
                  r_row   <= '0;
                  r_col   <= '0;
                  busy    <= 1'b1;
               end
            end
            S_MAC: begin
               r_col <= r_col + CW'(1);
               if (w_last_col) begin
                  // Final product folded in this edge via the MAC's next value.
                  matrix_result <= w_mac_acc;
                  result_idx    <= r_row;
                  matrix_valid  <= 1'b1;
                  r_col         <= '0;
                  r_state       <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (out_ready) begin
                  matrix_valid <= 1'b0;
                  if (w_last_row) begin
                     r_state <= S_DONE;
                  end else begin
                     r_row   <= r_row + RW'(1);
                     r_col   <= '0;
                     r_state <= S_MAC;
                  end
               end
            end
            S_DONE: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_vector_engine.sv
// Self-checking bench for matrix_vector_engine (M=N=3, DATA_WIDTH=8).
// Edge 0 is the clock edge that samples start; outputs are sampled on negedges.
module tb_matrix_vector_engine;

   localparam int M  = 3;
   localparam int N  = 3;
   localparam int DW = 8;

   typedef struct packed {
      logic [71:0] w;    // {w22,w21,w20,w12,w11,w10,w02,w01,w00}
      logic [23:0] x;    // {x2,x1,x0}
      logic [47:0] exp;  // {y2,y1,y0}
   } vec_t;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 start;
   logic signed [DW-1:0] w_in;
   logic                 w_wen;
   logic [1:0]           w_row;
   logic [1:0]           w_col;
   logic signed [DW-1:0] x_in;
   logic                 x_wen;
   logic [1:0]           x_addr;
   logic                 out_ready;
   logic [2*DW-1:0]      matrix_result;
   logic                 matrix_valid;
   logic [1:0]           result_idx;
   logic                 busy;
   logic                 done;

   int total = 0;
   int bad   = 0;
   vec_t vecs [4];

   matrix_vector_engine #(.M(M), .N(N), .DATA_WIDTH(DW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .w_in          (w_in),
      .w_wen         (w_wen),
      .w_row         (w_row),
      .w_col         (w_col),
      .x_in          (x_in),
      .x_wen         (x_wen),
      .x_addr        (x_addr),
      .out_ready     (out_ready),
      .matrix_result (matrix_result),
      .matrix_valid  (matrix_valid),
      .result_idx    (result_idx),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      start = 1'b0; w_wen = 1'b0; x_wen = 1'b0;
      w_row = '0; w_col = '0; w_in = '0; x_addr = '0; x_in = '0;
   endtask

   task automatic load_vec(input int v);
      logic [71:0] wv;
      logic [23:0] xv;
      wv = vecs[v].w;
      xv = vecs[v].x;
      for (int r = 0; r < M; r++) begin
         for (int c = 0; c < N; c++) begin
            @(negedge clk);
            w_wen = 1'b1; w_row = 2'(r); w_col = 2'(c);
            w_in  = wv[(r*N + c)*8 +: 8];
         end
      end
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         w_wen = 1'b0; x_wen = 1'b1; x_addr = 2'(i);
         x_in  = xv[i*8 +: 8];
      end
      @(negedge clk);
      idle_inputs();
   endtask

   // Run one computation with out_ready high; optionally hammer start/writes while busy.
   task automatic run_check(input int v, input bit disturb);
      logic [47:0] ev;
      int  row;
      bit  seen_done;
      ev = vecs[v].exp;
      row = 0;
      seen_done = 1'b0;
      out_ready = 1'b1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 1; k <= 40 && !seen_done; k++) begin
         @(negedge clk);
         if (k == 1) check("busy_after_start", 32'(busy), 32'd1);
         if (matrix_valid) begin
            if (row < M) begin
               check($sformatf("v%0d_r%0d_result", v, row), 32'(matrix_result), 32'(ev[row*16 +: 16]));
               check($sformatf("v%0d_r%0d_idx", v, row), 32'(result_idx), 32'(row));
               check($sformatf("v%0d_r%0d_cycle", v, row), 32'(k), 32'(N + row*(N+1)));
            end
            row++;
         end
         if (done) begin
            check($sformatf("v%0d_done_cycle", v), 32'(k), 32'(M*(N+1)+1));
            check($sformatf("v%0d_rows_seen", v), 32'(row), 32'(M));
            check($sformatf("v%0d_busy_at_done", v), 32'(busy), 32'd0);
            seen_done = 1'b1;
         end
         if (disturb && k <= 9) begin
            start = 1'b1; w_wen = 1'b1; w_row = 2'd0; w_col = 2'd0; w_in = 8'sd0;
            x_wen = 1'b1; x_addr = 2'd0; x_in = 8'sd0;
         end else begin
            idle_inputs();
         end
      end
      if (!seen_done) check($sformatf("v%0d_done_timeout", v), 32'd0, 32'd1);
      idle_inputs();
      @(negedge clk);
   endtask

   initial begin
      int  k;
      bit  seen;
      vecs[0] = '{w: {8'h01,8'h00,8'h00, 8'h00,8'h01,8'h00, 8'h00,8'h00,8'h01},
                  x: {8'h03,8'h02,8'h01},
                  exp: {16'h0003,16'h0002,16'h0001}};
      vecs[1] = '{w: {8'h7F,8'h7F,8'h7F, 8'h01,8'h01,8'h01, 8'h80,8'h80,8'h80},
                  x: {8'h80,8'h80,8'h80},
                  exp: {16'h4180,16'hFE80,16'hC000}};
      vecs[2] = '{w: {8'hFF,8'hFF,8'hFF, 8'h00,8'h00,8'h00, 8'h04,8'hFD,8'h02},
                  x: {8'hF9,8'h06,8'h05},
                  exp: {16'hFFFC,16'h0000,16'hFFDC}};
      vecs[3] = '{w: {8'h01,8'h00,8'h00, 8'h00,8'h7F,8'h80, 8'h7F,8'h7F,8'h7F},
                  x: {8'h7F,8'h7F,8'h7F},
                  exp: {16'h007F,16'hFF81,16'hBD03}};

      idle_inputs();
      out_ready = 1'b1;
      rst_n = 1'b0;
      #12;
      check("rst_result", 32'(matrix_result), 32'd0);
      check("rst_valid",  32'(matrix_valid), 32'd0);
      check("rst_idx",    32'(result_idx), 32'd0);
      check("rst_busy",   32'(busy), 32'd0);
      check("rst_done",   32'(done), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // Table-driven vectors.
      for (int v = 0; v < 4; v++) begin
         load_vec(v);
         run_check(v, 1'b0);
      end

      // Backpressure: hold out_ready low 5 cycles while row 0 is presented.
      out_ready = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      seen = 1'b0;
      k = 0;
      while (!seen && k < 20) begin
         @(negedge clk);
         k++;
         seen = matrix_valid;
      end
      check("stall_first_valid_cycle", 32'(k), 32'(N));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("stall%0d_valid", i),  32'(matrix_valid), 32'd1);
         check($sformatf("stall%0d_result", i), 32'(matrix_result), 32'h0000BD03);
         check($sformatf("stall%0d_idx", i),    32'(result_idx), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("stall_handshake_valid", 32'(matrix_valid), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      check("stall_done_seen", 32'(seen), 32'd1);
      @(negedge clk);

      // Reset during row 1 MAC: abandon, then rerun on retained operands.
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_result", 32'(matrix_result), 32'd0);
      check("midrst_valid",  32'(matrix_valid), 32'd0);
      check("midrst_idx",    32'(result_idx), 32'd0);
      check("midrst_busy",   32'(busy), 32'd0);
      check("midrst_done",   32'(done), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (matrix_valid || busy) seen = 1'b1;
      end
      check("midrst_quiet_after", 32'(seen), 32'd0);
      run_check(3, 1'b0);

      // start and operand writes while busy must be ignored.
      run_check(3, 1'b1);
      run_check(3, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/matrix_vector_engine.md
MATRIX_VECTOR_ENGINE -- requirements
Module: matrix_vector_engine

Interface
REQ-001 SHALL have parameter M, default 3: number of output rows (neurons).
REQ-002 SHALL have parameter N, default 3: number of input vector elements (columns).
REQ-003 SHALL have parameter DATA_WIDTH, default 8: signed weight and input width; result width is 2*DATA_WIDTH.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle request to compute all M rows.
REQ-007 w_in  input  DATA_WIDTH  signed weight write data.
REQ-008 w_wen  input  1  weight write enable.
REQ-009 w_row  input  max(1,$clog2(M))  weight row address; w_col  input  max(1,$clog2(N))  weight column address.
REQ-010 x_in  input  DATA_WIDTH  signed vector write data; x_wen  input  1  vector write enable; x_addr  input  max(1,$clog2(N))  vector index.
REQ-011 out_ready  input  1  downstream (neural layer) accepts result.
REQ-012 matrix_result  output  2*DATA_WIDTH  dot product of one row, two's complement.
REQ-013 matrix_valid  output  1  matrix_result holds a row result.
REQ-014 result_idx  output  max(1,$clog2(M))  row index of matrix_result.
REQ-015 busy  output  1  high in every state except IDLE; done  output  1  one-cycle pulse after last row accepted.

Function
REQ-016 SHALL store W[M][N] and x[N] in internal registers; writes take effect at the clk edge where the enable is high and state is IDLE; writes while busy SHALL be ignored.
REQ-017 SHALL implement states IDLE, MAC, EMIT, DONE.
REQ-018 IDLE: start high at an edge -> state MAC, row=0, col=0, acc=0; start in any other state SHALL be ignored.
REQ-019 MAC: each edge acc += sext(W[row][col]) * sext(x[col]), col increments; at the edge with col==N-1 the final sum SHALL load matrix_result, result_idx<=row, matrix_valid<=1, state EMIT.
REQ-020 First matrix_valid SHALL rise exactly N cycles after the edge sampling start.
REQ-021 Products are full signed 2*DATA_WIDTH; accumulation SHALL wrap modulo 2^(2*DATA_WIDTH), no saturation.
REQ-022 EMIT: matrix_valid, matrix_result, result_idx SHALL remain stable until an edge with out_ready high (handshake).
REQ-023 On handshake with row<M-1: matrix_valid<=0, row++, col=0, acc=0, state MAC; with row==M-1: matrix_valid<=0, state DONE.
REQ-024 DONE: done high for exactly one cycle, then state IDLE.
REQ-025 With out_ready held high, start-to-done latency SHALL be M*(N+1)+1 cycles; throughput one row per N+1 cycles.
REQ-026 out_ready while matrix_valid is low SHALL have no effect.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, matrix_result=0, matrix_valid=0, result_idx=0, busy=0, done=0, row/col/acc=0.
REQ-028 Reset mid-operation SHALL abandon the computation with no further matrix_valid; W and x contents are not cleared by reset.

Structure
REQ-029 Shared package nn_pkg SHALL hold ACC_WIDTH (2*DATA_WIDTH) and the state encoding constants.
REQ-030 The multiply-accumulate SHALL be a sub-module signed_mac (operands, acc in, clear, enable, acc out).

Verification
REQ-031 W=identity 3x3, x=[1,2,3], out_ready=1, start -> results 1,2,3 with result_idx 0,1,2; first valid N=3 cycles after start; done at cycle 13.
REQ-032 W row0 all -128, x all -128 -> matrix_result 16'hC000 (wrap of 49152).
REQ-033 W row0=[2,-3,4], x=[5,6,-7] -> matrix_result 16'hFFDC (-36).
REQ-034 out_ready low 5 cycles during EMIT -> matrix_valid, matrix_result, result_idx unchanged all 5 cycles; handshake on the 6th.
REQ-035 rst_n pulsed low mid-MAC on row 1 -> all outputs 0 immediately, no matrix_valid afterwards; rerun with start gives correct results without reloading W/x.
REQ-036 start and w_wen/x_wen asserted while busy -> ignored: result sequence and stored data unchanged.
